// File: rtl/lfsr_draw_sched.sv
// Round-robin draw scheduler sharing one 8-bit LFSR among N_REQ requesters.
// Owns the LFSR rst/enb controls, warm-up, lock-up re-seed and response channel.
module lfsr_draw_sched #(
    parameter int N_REQ  = 4,
    parameter int STEPS  = 1,
    parameter int WARMUP = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic                     lfsr_rst,
    output logic                     lfsr_enb,
    input  logic [7:0]               lfsr_q,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [7:0]               rsp_data,
    output logic                     busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(WARMUP + 1);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        STEP,
        CAPTURE,
        RECOVER,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IW-1:0]  ptr;
    logic [WW-1:0]  wcnt;
    logic [7:0]     scnt;
    logic           found;
    logic [IW-1:0]  win;
    logic           take;

    // First set request scanning from ptr upward, modulo N_REQ
    always_comb begin
        int k;
        k     = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            if (!found && req[k[IW-1:0]]) begin
                found = 1'b1;
                win   = k[IW-1:0];
            end
        end
    end

    assign take = (state == IDLE) && found;

    always_comb begin
        gnt = '0;
        if (take) gnt[win] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT:    if (wcnt == WW'(WARMUP - 1)) state_nx = IDLE;
            IDLE:    if (found) state_nx = STEP;
            STEP:    if (scnt == 8'd0) state_nx = CAPTURE;
            CAPTURE: state_nx = (lfsr_q == 8'h00) ? RECOVER : RESP;
            RECOVER: state_nx = STEP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = INIT;
        endcase
    end

    assign lfsr_rst  = (state == INIT) || (state == RECOVER);
    assign lfsr_enb  = (state == STEP);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            ptr      <= '0;
            wcnt     <= '0;
            scnt     <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT && state_nx == INIT) wcnt <= wcnt + 1'b1;
            if (take) begin
                ptr    <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
                rsp_id <= win;
                scnt   <= 8'(STEPS - 1);
            end
            // Re-seeded LFSR gets a full STEPS advance again
            if (state == RECOVER) scnt <= 8'(STEPS - 1);
            if (state == STEP && scnt != 8'd0) scnt <= scnt - 8'd1;
            if (state == CAPTURE) rsp_data <= lfsr_q;
        end
    end

endmodule

// File: doc/lfsr_draw_sched.md
# lfsr_draw_sched

Round-robin scheduler that shares one 8-bit `lfsr` random-number generator among `N_REQ` requesters in the auto_ra_pq design. It owns the LFSR's `rst`/`enb` controls and sequences a warm-up after reset. On each granted request it advances the LFSR by `STEPS` cycles, captures `q`, and returns the value with the requester ID over a valid/ready response channel. It also detects the all-zero lock-up state and re-seeds the LFSR.

## Interface
- `N_REQ`, default 4: number of requesters; minimum 2.
- `STEPS`, default 1: LFSR advances per draw; minimum 1, maximum 255.
- `WARMUP`, default 10: cycles `lfsr_rst` is held after reset release; minimum 1.
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, `N_REQ`: per-requester draw request (level). The requester holds it until it sees `gnt`.
- `gnt`, out, `N_REQ`: one-hot grant, a single-cycle pulse.
- `lfsr_rst`, out, 1: drives `lfsr.rst`, active-high.
- `lfsr_enb`, out, 1: drives `lfsr.enb`.
- `lfsr_q`, in, 8: `lfsr.q`.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_id`, out, `$clog2(N_REQ)`: index of the granted requester.
- `rsp_data`, out, 8: captured LFSR value.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- States:
  - INIT: `lfsr_rst`=1 for `WARMUP` cycles, then go to IDLE.
  - IDLE: arbitrate. If any `req` bit is set, pulse `gnt`, then go to STEP.
  - STEP: `lfsr_enb`=1 for exactly `STEPS` cycles, then go to CAPTURE.
  - CAPTURE: 1 cycle. `rsp_data`<=`lfsr_q`. If `lfsr_q`==0, go to RECOVER; otherwise go to RESP.
  - RECOVER: `lfsr_rst`=1 for 1 cycle, then go to STEP (a full `STEPS` advance again). `rsp_id` is retained.
  - RESP: `rsp_valid`=1 until `rsp_valid && rsp_ready`, then go to IDLE.
- Arbitration:
  - Round-robin pointer `ptr`, reset to 0.
  - Winner is the first set `req` bit scanning `ptr`, `ptr`+1, … modulo `N_REQ`.
  - On grant, `ptr` <= winner+1 (wraps `N_REQ`-1 to 0). `rsp_id` <= winner.
  - `gnt` is combinational from the registered state and `req`, and is only ever high in IDLE.
- Only one draw is outstanding at a time. `req` is ignored outside IDLE; requests are never queued.
- Step counter: 8-bit, loaded with `STEPS`-1 on STEP entry and decremented to 0. It is reloaded on re-entry from RECOVER.
- `lfsr_enb` and `lfsr_rst` are never high in the same cycle.
- `rsp_data` and `rsp_id` stay stable while `rsp_valid`=1 and `rsp_ready`=0.
- Reset (`rst_n` low, asynchronous, any state):
  - Outputs: state=INIT, `ptr`=0, `gnt`=0, `lfsr_enb`=0, `lfsr_rst`=1, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=1.
  - An in-flight draw or pending response is discarded with no `gnt` replay.
  - The `WARMUP` count restarts from the rising edge of `rst_n`.

## Timing
- Let T be the IDLE cycle in which `gnt` pulses.
  - `lfsr_enb` is high during T+1 … T+`STEPS`.
  - CAPTURE occurs at T+`STEPS`+1.
  - `rsp_valid` rises at T+`STEPS`+2.
- With the default `STEPS`=1: grant→`rsp_valid` latency is 3 cycles.
- Handshake completes at T+`STEPS`+2 when `rsp_ready` is already high. The next `gnt` is possible at T+`STEPS`+3.
- Each lock-up recovery adds `STEPS`+2 cycles (RECOVER + STEP + CAPTURE).
- After `rst_n` rises, `lfsr_rst` is high for exactly `WARMUP` cycles. The earliest `gnt` is in cycle `WARMUP`+1.
- `lfsr_q` is sampled one cycle after the last `lfsr_enb` cycle. This matches `lfsr` registering its shift on the same edge that samples `enb`.

## Test plan
- **Warm-up:** reset, release `rst_n`, hold `req`=4'b0001.
  - `lfsr_rst` stays high for 10 cycles.
  - `gnt`=0001 arrives in cycle 11.
  - `rsp_valid` arrives 3 cycles later with `rsp_id`=0 and `rsp_data` equal to the bench's `lfsr` model value after 1 step.
- **Round-robin:** hold `req`=4'b1111 with `rsp_ready`=1 for 8 draws.
  - Grant order is 0,1,2,3,0,1,2,3.
  - Each `rsp_data` equals successive LFSR model states.
  - IDLE is revisited every 4 cycles.
- **Back-pressure:** hold `rsp_ready`=0 for 20 cycles during RESP.
  - `rsp_valid`, `rsp_id`, `rsp_data` stay constant.
  - `lfsr_enb`=0 throughout.
  - No `gnt` is issued despite `req`=4'b0110.
- **Lock-up:** force `lfsr_q`=8'h00 in CAPTURE.
  - `lfsr_rst` pulses for 1 cycle, followed by `STEPS` `lfsr_enb` cycles.
  - The non-zero recaptured value is returned with the original `rsp_id`.
- **Reset mid-draw:** drop `rst_n` during STEP, and separately during RESP.
  - Immediately: `rsp_valid`=0, `lfsr_enb`=0, `lfsr_rst`=1.
  - After release, `ptr`=0: with `req`=4'b1010, the first `gnt` is 0010.
- **Wrap and sparse requests:** grant requester 3, then hold `req`=4'b1001.
  - The next grant is 0001 (pointer wraps to 0), then 1000.
  - Run again with `STEPS`=5 to check 5 `lfsr_enb` cycles per draw and a 7-cycle grant→valid latency.
